// File: rtl/stop_it_pkg.sv
// Shared types and helpers for the Stop It game blocks (controller, counter, display).
package stop_it_pkg;

    typedef enum logic [2:0] {IDLE, ARM, RUN, WIN, LOSE} state_e;

    localparam int                 COUNT_W   = 5;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 5'h1F;
    localparam int                 LFSR_W    = 5;

    // x^5 + x^3 + 1 Fibonacci step; maximal length 31, never reaches 0 from a non-zero seed
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[3:0], s[4] ^ s[2]};
    endfunction

endpackage

// File: rtl/stop_it_lfsr.sv
// Free-running 5-bit LFSR used as the target source; reloads SEED on reset.
module stop_it_lfsr
    import stop_it_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 5'h01
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] o_value
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= SEED;
        else          r_state <= lfsr_next(r_state);
    end

    assign o_value = r_state;

endmodule

// File: rtl/stop_it_game_ctrl.sv
// Stop It game controller: drives the down-counter, draws a target, judges the stop press
// and keeps a saturating consecutive-win score. Runs entirely in the 4 Hz clock domain.
module stop_it_game_ctrl
    import stop_it_pkg::*;
#(
    parameter int                HOLD_CYCLES = 8,
    parameter int                TOL         = 0,
    parameter int                SCORE_W     = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 5'h01
) (
    input  logic               clk_4_i,
    input  logic               rst_ni,
    input  logic               go_i,
    input  logic               stop_i,
    input  logic [COUNT_W-1:0] count_i,
    output logic               counter_rst_no,
    output logic               counter_en_o,
    output logic [COUNT_W-1:0] target_o,
    output logic               win_o,
    output logic               lose_o,
    output logic               busy_o,
    output logic [SCORE_W-1:0] score_o
);

    localparam int                 HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W:0]   TOL_V     = (COUNT_W + 1)'(TOL);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e             r_state;
    logic               r_go_prev;
    logic               r_stop_prev;
    logic [COUNT_W-1:0] r_target;
    logic [SCORE_W-1:0] r_score;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_win;
    logic               r_lose;
    logic               r_busy;

    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_go_rise;
    logic               w_stop_rise;
    logic [COUNT_W:0]   w_diff;
    logic [COUNT_W:0]   w_mag;
    logic               w_hit;
    logic               w_count_zero;

    stop_it_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (clk_4_i),
        .i_rst_n (rst_ni),
        .o_value (w_lfsr)
    );

    // prev registers reset high so a button held through reset never looks like a press
    assign w_go_rise    = go_i & ~r_go_prev;
    assign w_stop_rise  = stop_i & ~r_stop_prev;

    // one extra bit keeps the signed difference exact before taking its magnitude
    assign w_diff       = {1'b0, count_i} - {1'b0, r_target};
    assign w_mag        = w_diff[COUNT_W] ? -w_diff : w_diff;
    assign w_hit        = (w_mag <= TOL_V);
    assign w_count_zero = (count_i == '0);

    // stop press freezes the count in the decision cycle; count 0 halts without wrapping
    assign counter_en_o   = (r_state == RUN) & ~w_stop_rise & ~w_count_zero;
    assign counter_rst_no = rst_ni & (r_state != ARM);

    always_ff @(posedge clk_4_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_go_prev   <= 1'b1;
            r_stop_prev <= 1'b1;
            r_target    <= '0;
            r_score     <= '0;
            r_hold      <= '0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_go_prev   <= go_i;
            r_stop_prev <= stop_i;
            case (r_state)
                IDLE: begin
                    if (w_go_rise) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    r_target <= w_lfsr;
                    r_state  <= RUN;
                end
                RUN: begin
                    if (w_stop_rise || w_count_zero) begin
                        r_busy <= 1'b0;
                        r_hold <= '0;
                        if (w_stop_rise && w_hit) begin
                            r_state <= WIN;
                            r_win   <= 1'b1;
                            if (r_score != SCORE_MAX) r_score <= r_score + SCORE_W'(1);
                        end else begin
                            r_state <= LOSE;
                            r_lose  <= 1'b1;
                            r_score <= '0;
                        end
                    end
                end
                WIN, LOSE: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= IDLE;
                        r_hold  <= '0;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_win   <= 1'b0;
                    r_lose  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign target_o = r_target;
    assign win_o    = r_win;
    assign lose_o   = r_lose;
    assign busy_o   = r_busy;
    assign score_o  = r_score;

endmodule

// File: tb/tb_stop_it_game_ctrl.sv
// Closed-loop bench: two controllers (TOL=0 and TOL=1) each driving a behavioural game_counter.
module tb_stop_it_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, go, stop;
    logic       crst_a, en_a, win_a, lose_a, busy_a;
    logic       crst_b, en_b, win_b, lose_b, busy_b;
    logic [4:0] tgt_a, tgt_b, cnt_a, cnt_b;
    logic [3:0] score_a, score_b;

    stop_it_game_ctrl #(.HOLD_CYCLES(8), .TOL(0), .SCORE_W(4), .LFSR_SEED(5'h01)) dut_a (
        .clk_4_i(clk), .rst_ni(rst_n), .go_i(go), .stop_i(stop), .count_i(cnt_a),
        .counter_rst_no(crst_a), .counter_en_o(en_a), .target_o(tgt_a),
        .win_o(win_a), .lose_o(lose_a), .busy_o(busy_a), .score_o(score_a));

    stop_it_game_ctrl #(.HOLD_CYCLES(8), .TOL(1), .SCORE_W(4), .LFSR_SEED(5'h01)) dut_b (
        .clk_4_i(clk), .rst_ni(rst_n), .go_i(go), .stop_i(stop), .count_i(cnt_b),
        .counter_rst_no(crst_b), .counter_en_o(en_b), .target_o(tgt_b),
        .win_o(win_b), .lose_o(lose_b), .busy_o(busy_b), .score_o(score_b));

    // game_counter stand-ins: reload to 31 when reset low, decrement when enabled
    always @(posedge clk) begin
        if (!crst_a) cnt_a <= 5'h1F; else if (en_a) cnt_a <= cnt_a - 5'd1;
        if (!crst_b) cnt_b <= 5'h1F; else if (en_b) cnt_b <= cnt_b - 5'd1;
    end

    // reference LFSR, x^5+x^3+1 from seed 01, stepping every non-reset cycle
    logic [4:0] m_lfsr;
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 5'h01;
        else        m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    end

    int         n_err = 0;
    int         n_chk = 0;
    int         exp_sa = 0;
    int         exp_sb = 0;
    logic [4:0] exp_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input bit hold_go);
        go = 1'b1;
        step();
        chk("arm_busy", busy_a, 1);
        chk("arm_crst_a", crst_a, 0);
        chk("arm_crst_b", crst_b, 0);
        exp_tgt = m_lfsr;
        if (!hold_go) go = 1'b0;
        step();
        chk("tgt_a", tgt_a, exp_tgt);
        chk("tgt_b", tgt_b, exp_tgt);
        chk("tgt_nz", tgt_a != 5'd0, 1);
        chk("run_cnt31", cnt_a, 31);
        chk("run_crst_hi", crst_a, 1);
        chk("run_busy", busy_a, 1);
    endtask

    task automatic play(input int off, input bit wa, input bit wb, input bit poke);
        int w;
        int n;
        start_game(1'b0);
        w = int'(exp_tgt) + off;
        if (w > 31) w = int'(exp_tgt) - off;
        n = 0;
        while (cnt_a != w[4:0] && n < 40) begin
            step();
            n++;
        end
        chk("reach_cnt", cnt_a, w);
        stop = 1'b1;
        #1;
        chk("freeze_en_a", en_a, 0);
        chk("freeze_en_b", en_b, 0);
        step();
        exp_sa = wa ? ((exp_sa < 15) ? exp_sa + 1 : 15) : 0;
        exp_sb = wb ? ((exp_sb < 15) ? exp_sb + 1 : 15) : 0;
        chk("win_a", win_a, wa);
        chk("lose_a", lose_a, !wa);
        chk("win_b", win_b, wb);
        chk("lose_b", lose_b, !wb);
        chk("score_a", score_a, exp_sa);
        chk("score_b", score_b, exp_sb);
        chk("frozen_cnt", cnt_a, w);
        chk("end_busy", busy_a, 0);
        stop = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (poke && i == 3) begin stop = 1'b1; go = 1'b1; end
            if (poke && i == 4) begin stop = 1'b0; go = 1'b0; end
            step();
            chk("hold_res_a", wa ? win_a : lose_a, 1);
            chk("hold_busy", busy_a, 0);
        end
        step();
        chk("idle_win", win_a, 0);
        chk("idle_lose", lose_a, 0);
        chk("idle_busy", busy_a, 0);
        chk("idle_cnt", cnt_a, w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b1; stop = 1'b1;
        // reset held 3 cycles with both buttons pressed
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_win", win_a, 0);
            chk("rst_lose", lose_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_tgt", tgt_a, 0);
            chk("rst_score", score_a, 0);
            chk("rst_en", en_a, 0);
            chk("rst_crst", crst_a, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_crst", crst_a, 1);
        step();
        step();
        chk("no_false_arm", busy_a, 0);
        go = 1'b0; stop = 1'b0;
        step();

        // exact hit wins, with go/stop pokes during WIN
        play(0, 1'b1, 1'b1, 1'b1);
        // off by one: lose at TOL=0, win at TOL=1
        play(1, 1'b0, 1'b1, 1'b0);

        // timeout: count runs to 0, halts, then LOSE
        start_game(1'b0);
        begin
            int n;
            n = 0;
            while (cnt_a != 5'd0 && n < 40) begin
                step();
                n++;
            end
        end
        chk("to_reach0", cnt_a, 0);
        chk("to_en0", en_a, 0);
        step();
        exp_sa = 0; exp_sb = 0;
        chk("to_lose_a", lose_a, 1);
        chk("to_lose_b", lose_b, 1);
        chk("to_nowrap", cnt_a, 0);
        chk("to_score_b", score_b, 0);
        for (int i = 1; i < 8; i++) step();
        chk("to_hold_last", lose_a, 1);
        step();
        chk("to_idle", lose_a, 0);
        chk("to_cnt_stays0", cnt_a, 0);

        // 16 consecutive wins saturate the 4-bit score
        for (int g = 0; g < 16; g++) play(0, 1'b1, 1'b1, 1'b0);
        chk("sat_score_a", score_a, 15);
        chk("sat_score_b", score_b, 15);

        // reset in the middle of RUN while go is held
        start_game(1'b1);
        begin
            int n;
            n = 0;
            while (cnt_a != 5'd17 && n < 40) begin
                step();
                n++;
            end
        end
        chk("mid_cnt17", cnt_a, 17);
        chk("mid_busy_go_held", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_crst_comb", crst_a, 0);
        step();
        exp_sa = 0; exp_sb = 0;
        chk("mid_busy", busy_a, 0);
        chk("mid_tgt", tgt_a, 0);
        chk("mid_score", score_a, 0);
        chk("mid_cnt31", cnt_a, 31);
        chk("mid_en", en_a, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("mid_go_held_no_arm", busy_a, 0);
        go = 1'b0;
        step();
        stop = 1'b1;
        step();
        chk("idle_stop_busy", busy_a, 0);
        chk("idle_stop_win", win_a, 0);
        chk("idle_stop_lose", lose_a, 0);
        stop = 1'b0;
        step();

        play(0, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
